ps2_keyboard_rx: RTL
====================

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8, meaning consecutive equal synchronized ps2_clk samples required to change the filtered clock level.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning onboard_clock cycles without a filtered falling edge before a partial frame is abandoned (1 ms at 50 MHz).
REQ-003 The block SHALL have port onboard_clock  in  1  sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port ps2_clk  in  1  raw keyboard clock, asynchronous, idle high.
REQ-006 The block SHALL have port ps2_data  in  1  raw keyboard data, asynchronous, idle high.
REQ-007 The block SHALL have port keypress_data  out  8  code of the currently held key, 0x00 when none; feeds static_ram keypress_data.
REQ-008 The block SHALL have port frame_error  out  1  one-cycle pulse per rejected or timed-out frame.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer; ps2_clk then passes a FILTER_LEN-sample level filter (filtered level initializes high).
REQ-010 A falling edge SHALL be a filtered-clock transition 1->0; ps2_data (synchronized) is sampled on the same cycle the edge is detected.
REQ-011 Frame FSM states: IDLE, DATA, PARITY, STOP; IDLE->DATA on edge with data=0; IDLE stays IDLE on edge with data=1 (no error).
REQ-012 DATA SHALL shift in 8 bits LSB first, a 3-bit counter 0..7, ->PARITY after bit 7.
REQ-013 PARITY SHALL capture the parity bit, ->STOP; STOP captures the stop bit, ->IDLE.
REQ-014 A frame SHALL be valid iff odd parity over data+parity holds and stop=1; valid frame asserts internal byte_valid for exactly 1 cycle, the cycle after the stop-bit edge.
REQ-015 An invalid frame SHALL pulse frame_error for 1 cycle (same cycle byte_valid would have fired) and discard the byte.
REQ-016 A timeout counter SHALL clear on every falling edge and in IDLE; reaching TIMEOUT_CYCLES outside IDLE forces IDLE and pulses frame_error once.
REQ-017 Decoder: byte 0xE0 sets ext flag; byte 0xF0 sets brk flag; both flags clear after the next non-prefix byte.
REQ-018 Code mapping: non-extended 0x01..0x7F map to themselves; extended 0x75/0x72/0x6B/0x74 map to 0x80/0x81/0x82/0x83; all other bytes (including non-extended 0x83, extended others, 0x00, 0xAA, 0xFA, 0xFE) are ignored and clear flags.
REQ-019 Make of a mapped code SHALL load keypress_data with it (replacing any held code; repeated make of the same code leaves it unchanged).
REQ-020 Break of a mapped code SHALL clear keypress_data to 0x00 only if it equals the held code; otherwise keypress_data is unchanged.
REQ-021 keypress_data SHALL update on the cycle after byte_valid, i.e. 2 onboard_clock cycles after the stop-bit falling edge is detected.
REQ-022 frame_error and byte processing SHALL NOT affect prefix flags on an invalid frame; a timeout SHALL clear ext and brk.

Reset
REQ-023 Reset SHALL immediately force: FSM IDLE, shift/bit/timeout counters 0, synchronizers and filtered clock 1, ext=brk=0, keypress_data=0x00, frame_error=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; the first frame accepted afterwards must begin with a new start bit.
REQ-025 Reset deassertion SHALL be synchronized externally; the block requires no post-reset idle period beyond FILTER_LEN cycles.

Structure
REQ-026 A shared package SHALL hold PS2_PREFIX_EXT=0xE0, PS2_PREFIX_BRK=0xF0, the four arrow scan codes and their mapped codes 0x80..0x83, and the FSM state enumeration.
REQ-027 Sub-module ps2_frame_rx SHALL contain synchronizers, filter, frame FSM and timeout, outputting byte, byte_valid, frame_error; the top holds decode and keypress_data.

Verification
REQ-028 Frame 0x1C (A) make, bit period 60 us -> keypress_data=0x1C exactly 2 cycles after stop edge; then F0,1C -> 0x00.
REQ-029 E0,75 then E0,F0,75 -> keypress_data 0x80 then 0x00; 0x75 alone -> 0x75.
REQ-030 Make 0x1C, make 0x1B, break 0x1C -> keypress_data 0x1B held (break of non-held ignored).
REQ-031 Frame 0x1C with even parity, then frame with stop=0 -> two 1-cycle frame_error pulses, keypress_data stays 0x00.
REQ-032 Start bit plus 4 data bits then ps2_clk held high 1.2 ms -> one frame_error at TIMEOUT_CYCLES, next full 0x29 frame -> keypress_data=0x29.
REQ-033 ps2_clk glitches of 3 cycles low during idle -> no state change; reset asserted after bit 5 of a frame -> keypress_data=0x00, FSM IDLE, trailing bits produce no output.

Source files
------------

// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants, FSM state type and scan-code mapping for the PS/2 keyboard receiver.
package ps2_keyboard_rx_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

   localparam logic [7:0] PS2_SC_UP    = 8'h75;
   localparam logic [7:0] PS2_SC_DOWN  = 8'h72;
   localparam logic [7:0] PS2_SC_LEFT  = 8'h6B;
   localparam logic [7:0] PS2_SC_RIGHT = 8'h74;

   localparam logic [7:0] KEY_UP    = 8'h80;
   localparam logic [7:0] KEY_DOWN  = 8'h81;
   localparam logic [7:0] KEY_LEFT  = 8'h82;
   localparam logic [7:0] KEY_RIGHT = 8'h83;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_t;

   typedef struct packed {
      logic       hit;
      logic [7:0] code;
   } key_map_t;

   // Extended set only knows the four arrows; plain set passes 0x01..0x7F through.
   function automatic key_map_t map_scan(input logic ext, input logic [7:0] sc);
      key_map_t m;
      m.hit  = 1'b0;
      m.code = 8'h00;
      if (ext) begin
         case (sc)
            PS2_SC_UP:    begin m.hit = 1'b1; m.code = KEY_UP;    end
            PS2_SC_DOWN:  begin m.hit = 1'b1; m.code = KEY_DOWN;  end
            PS2_SC_LEFT:  begin m.hit = 1'b1; m.code = KEY_LEFT;  end
            PS2_SC_RIGHT: begin m.hit = 1'b1; m.code = KEY_RIGHT; end
            default:      m.hit = 1'b0;
         endcase
      end else if (sc != 8'h00 && !sc[7]) begin
         m.hit  = 1'b1;
         m.code = sc;
      end
      return m;
   endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 line inputs and decoded key outputs of the keyboard receiver.
interface ps2_keyboard_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keypress_data;
   logic       frame_error;

   modport master (output ps2_clk, ps2_data, input keypress_data, frame_error);
   modport slave  (input ps2_clk, ps2_data, output keypress_data, frame_error);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 line front end: synchronizers, clock glitch filter, 11-bit frame FSM and frame timeout.
module ps2_frame_rx
   import ps2_keyboard_rx_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_error,
   output logic       o_timeout
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    r_clk_sync, r_dat_sync;
   logic [FW-1:0] r_flt_cnt;
   logic          r_clk_flt, r_clk_flt_d;
   ps2_state_t    r_state;
   logic [7:0]    r_shift;
   logic [2:0]    r_bit_cnt;
   logic          r_parity;
   logic [TW-1:0] r_to_cnt;
   logic          r_byte_valid, r_frame_error, r_timeout;

   logic w_clk_s, w_dat_s, w_fall, w_frame_ok;
   assign w_clk_s    = r_clk_sync[1];
   assign w_dat_s    = r_dat_sync[1];
   assign w_fall     = r_clk_flt_d & ~r_clk_flt;
   assign w_frame_ok = (^{r_shift, r_parity}) & w_dat_s;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
      end else begin
         r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
         r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      end
   end

   // Level only flips after FILTER_LEN consecutive samples disagree with it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_flt_cnt   <= '0;
         r_clk_flt   <= 1'b1;
         r_clk_flt_d <= 1'b1;
      end else begin
         r_clk_flt_d <= r_clk_flt;
         if (w_clk_s == r_clk_flt) begin
            r_flt_cnt <= '0;
         end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
            r_clk_flt <= w_clk_s;
            r_flt_cnt <= '0;
         end else begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_parity      <= 1'b0;
         r_to_cnt      <= '0;
         r_byte_valid  <= 1'b0;
         r_frame_error <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_byte_valid  <= 1'b0;
         r_frame_error <= 1'b0;
         r_timeout     <= 1'b0;
         if (w_fall) begin
            r_to_cnt <= '0;
            case (r_state)
               ST_IDLE: if (!w_dat_s) begin
                  r_state   <= ST_DATA;
                  r_bit_cnt <= '0;
               end
               ST_DATA: begin
                  r_shift   <= {w_dat_s, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
               end
               ST_PARITY: begin
                  r_parity <= w_dat_s;
                  r_state  <= ST_STOP;
               end
               ST_STOP: begin
                  r_state       <= ST_IDLE;
                  r_byte_valid  <= w_frame_ok;
                  r_frame_error <= ~w_frame_ok;
               end
               default: r_state <= ST_IDLE;
            endcase
         end else if (r_state == ST_IDLE) begin
            r_to_cnt <= '0;
         end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Keyboard went quiet mid-frame: drop the partial byte.
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_to_cnt      <= '0;
            r_frame_error <= 1'b1;
            r_timeout     <= 1'b1;
         end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
      end
   end

   assign o_byte        = r_shift;
   assign o_byte_valid  = r_byte_valid;
   assign o_frame_error = r_frame_error;
   assign o_timeout     = r_timeout;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame front end plus make/break decode into the held key code.
module ps2_keyboard_rx
   import ps2_keyboard_rx_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic              onboard_clock,
   input  logic              reset,
   ps2_keyboard_rx_if.slave  ps2
);

   logic [7:0] w_byte;
   logic       w_byte_valid, w_frame_error, w_timeout;
   key_map_t   w_map;

   logic       r_ext, r_brk;
   logic [7:0] r_key;

   ps2_frame_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame (
      .i_clk         (onboard_clock),
      .i_rst         (reset),
      .i_ps2_clk     (ps2.ps2_clk),
      .i_ps2_data    (ps2.ps2_data),
      .o_byte        (w_byte),
      .o_byte_valid  (w_byte_valid),
      .o_frame_error (w_frame_error),
      .o_timeout     (w_timeout)
   );

   assign w_map = map_scan(r_ext, w_byte);

   // Prefixes only arm flags; any other byte consumes them whether or not it maps.
   always_ff @(posedge onboard_clock or posedge reset) begin
      if (reset) begin
         r_ext <= 1'b0;
         r_brk <= 1'b0;
         r_key <= 8'h00;
      end else if (w_timeout) begin
         r_ext <= 1'b0;
         r_brk <= 1'b0;
      end else if (w_byte_valid) begin
         if (w_byte == PS2_PREFIX_EXT) begin
            r_ext <= 1'b1;
         end else if (w_byte == PS2_PREFIX_BRK) begin
            r_brk <= 1'b1;
         end else begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
            if (w_map.hit) begin
               if (!r_brk)                   r_key <= w_map.code;
               else if (r_key == w_map.code) r_key <= 8'h00;
            end
         end
      end
   end

   assign ps2.keypress_data = r_key;
   assign ps2.frame_error   = w_frame_error;

endmodule
